// File: rtl/accumulator_control_unit_pkg.sv
// Shared definitions for the accumulator CPU control path: opcodes, FSM states,
// mux-select encodings and the bundled control word.
package cpu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDAC = 8'h01;
  localparam logic [7:0] OP_STAC = 8'h02;
  localparam logic [7:0] OP_MVAC = 8'h03;
  localparam logic [7:0] OP_MOVR = 8'h04;
  localparam logic [7:0] OP_JUMP = 8'h05;
  localparam logic [7:0] OP_JMPZ = 8'h06;
  localparam logic [7:0] OP_JPNZ = 8'h07;
  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_INAC = 8'h0A;
  localparam logic [7:0] OP_CLAC = 8'h0B;
  localparam logic [7:0] OP_AND  = 8'h0C;
  localparam logic [7:0] OP_OR   = 8'h0D;
  localparam logic [7:0] OP_XOR  = 8'h0E;
  localparam logic [7:0] OP_NOT  = 8'h0F;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    ADDR1  = 4'd2,
    ADDR2  = 4'd3,
    EXEC   = 4'd4,
    LOAD2  = 4'd5,
    HALT   = 4'd6
  } state_t;

  typedef enum logic [1:0] {
    JC_ALWAYS = 2'd0,
    JC_ZERO   = 2'd1,
    JC_NZERO  = 2'd2
  } jump_cond_t;

  localparam logic PCSEL_INC      = 1'b0;
  localparam logic PCSEL_ADDR     = 1'b1;
  localparam logic ADDRSEL_PC     = 1'b0;
  localparam logic ADDRSEL_OPND   = 1'b1;
  localparam logic ACSEL_ALU      = 1'b0;
  localparam logic ACSEL_DATA     = 1'b1;
  localparam logic ACSRC_R        = 1'b0;
  localparam logic ACSRC_DREG     = 1'b1;
  localparam logic ZSEL_ALU       = 1'b0;
  localparam logic ZSEL_ACW       = 1'b1;

  typedef struct packed {
    logic we_ac;
    logic we_r;
    logic we_mem;
    logic pc_en;
    logic ir_en;
    logic dr_en;
    logic msb_en;
    logic lsb_en;
    logic z_en;
    logic sel_pc;
    logic sel_zero;
    logic sel_addr;
    logic sel_alu_to_ac;
    logic sel_mem_or_r;
    logic instr_done;
    logic halted;
  } ctrl_t;

  function automatic logic jump_taken(input jump_cond_t cond, input logic ac_zero);
    logic taken;
    case (cond)
      JC_ALWAYS: taken = 1'b1;
      JC_ZERO:   taken = ac_zero;
      JC_NZERO:  taken = ~ac_zero;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/accumulator_control_unit_if.sv
// Control/status bundle between the control unit (master) and the datapath (slave).
interface accumulator_control_unit_if #(parameter int STATE_W = 4);
  logic               run;
  logic [7:0]         instructionOut;
  logic               ACisZero;
  logic               writeEnableAC;
  logic               writeEnableR;
  logic               writeEnableMem;
  logic               PCEnable;
  logic               instructionRegisterEnable;
  logic               dataRegisterEnable;
  logic               MSBaddressEnable;
  logic               LSBaddressEnable;
  logic               zeroEnable;
  logic               muxSelectPC;
  logic               muxSelectZero;
  logic               muxSelectAddress;
  logic               muxSelectALUtoAC;
  logic               muxSelectMEM_or_R_toAC;
  logic               instrDone;
  logic               halted;
  logic [STATE_W-1:0] stateOut;

  modport master (
    input  run, instructionOut, ACisZero,
    output writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
           instructionRegisterEnable, dataRegisterEnable, MSBaddressEnable,
           LSBaddressEnable, zeroEnable, muxSelectPC, muxSelectZero,
           muxSelectAddress, muxSelectALUtoAC, muxSelectMEM_or_R_toAC,
           instrDone, halted, stateOut
  );

  modport slave (
    output run, instructionOut, ACisZero,
    input  writeEnableAC, writeEnableR, writeEnableMem, PCEnable,
           instructionRegisterEnable, dataRegisterEnable, MSBaddressEnable,
           LSBaddressEnable, zeroEnable, muxSelectPC, muxSelectZero,
           muxSelectAddress, muxSelectALUtoAC, muxSelectMEM_or_R_toAC,
           instrDone, halted, stateOut
  );
endinterface

// File: rtl/accumulator_control_unit_opcode_decode.sv
// Maps a latched opcode to instruction class flags; unknown opcodes fall out as NOP.
module opcode_decode
  import cpu_pkg::*;
#(
  parameter logic [7:0] HALT_OP = OP_HALT
) (
  input  logic [7:0] opcode_i,
  output logic       needs_addr_o,
  output logic       is_load_o,
  output logic       is_store_o,
  output logic       is_jump_o,
  output jump_cond_t jump_cond_o,
  output logic       is_alu_o,
  output logic       is_mvac_o,
  output logic       is_movr_o,
  output logic       is_halt_o
);

  // HALT_OP is checked first so it wins even if placed inside the defined range
  always_comb begin
    needs_addr_o = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_jump_o    = 1'b0;
    jump_cond_o  = JC_ALWAYS;
    is_alu_o     = 1'b0;
    is_mvac_o    = 1'b0;
    is_movr_o    = 1'b0;
    is_halt_o    = 1'b0;
    if (opcode_i == HALT_OP) begin
      is_halt_o = 1'b1;
    end else begin
      case (opcode_i)
        OP_LDAC: begin needs_addr_o = 1'b1; is_load_o  = 1'b1; end
        OP_STAC: begin needs_addr_o = 1'b1; is_store_o = 1'b1; end
        OP_MVAC: is_mvac_o = 1'b1;
        OP_MOVR: is_movr_o = 1'b1;
        OP_JUMP: begin needs_addr_o = 1'b1; is_jump_o = 1'b1; end
        OP_JMPZ: begin needs_addr_o = 1'b1; is_jump_o = 1'b1; jump_cond_o = JC_ZERO;  end
        OP_JPNZ: begin needs_addr_o = 1'b1; is_jump_o = 1'b1; jump_cond_o = JC_NZERO; end
        OP_ADD, OP_SUB, OP_INAC, OP_CLAC,
        OP_AND, OP_OR, OP_XOR, OP_NOT: is_alu_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/accumulator_control_unit.sv
// Moore-style sequencer for the 8-bit accumulator datapath: FETCH, DECODE,
// operand-address fetch, EXEC and the second LDAC cycle, plus a sticky HALT.
module accumulator_control_unit
  import cpu_pkg::*;
#(
  parameter logic [7:0] HALT_OP = 8'hFF,
  parameter int         STATE_W = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  accumulator_control_unit_if.master  bus
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_s, ctrl_out_s;
  logic       needs_addr_s, is_load_s, is_store_s, is_jump_s;
  logic       is_alu_s, is_mvac_s, is_movr_s, is_halt_s;
  jump_cond_t jump_cond_s;

  opcode_decode #(.HALT_OP(HALT_OP)) u_decode (
    .opcode_i     (bus.instructionOut),
    .needs_addr_o (needs_addr_s),
    .is_load_o    (is_load_s),
    .is_store_o   (is_store_s),
    .is_jump_o    (is_jump_s),
    .jump_cond_o  (jump_cond_s),
    .is_alu_o     (is_alu_s),
    .is_mvac_o    (is_mvac_s),
    .is_movr_o    (is_movr_s),
    .is_halt_o    (is_halt_s)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next-state and control-word decode
  always_comb begin
    ctrl_s  = '0;
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (bus.run) begin
          ctrl_s.ir_en = 1'b1;
          ctrl_s.pc_en = 1'b1;
          state_d      = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: begin
        if (is_halt_s)         state_d = HALT;
        else if (needs_addr_s) state_d = ADDR1;
        else                   state_d = EXEC;
      end
      ADDR1: begin
        ctrl_s.msb_en = 1'b1;
        ctrl_s.pc_en  = 1'b1;
        state_d       = ADDR2;
      end
      ADDR2: begin
        ctrl_s.lsb_en = 1'b1;
        ctrl_s.pc_en  = 1'b1;
        state_d       = EXEC;
      end
      EXEC: begin
        ctrl_s.instr_done = 1'b1;
        state_d           = FETCH;
        if (is_load_s) begin
          // Data register captures memory now; AC is written in LOAD2
          ctrl_s.sel_addr   = ADDRSEL_OPND;
          ctrl_s.dr_en      = 1'b1;
          ctrl_s.instr_done = 1'b0;
          state_d           = LOAD2;
        end else if (is_store_s) begin
          ctrl_s.sel_addr = ADDRSEL_OPND;
          ctrl_s.we_mem   = 1'b1;
        end else if (is_jump_s) begin
          if (jump_taken(jump_cond_s, bus.ACisZero)) begin
            ctrl_s.sel_pc = PCSEL_ADDR;
            ctrl_s.pc_en  = 1'b1;
          end else begin
            ctrl_s.sel_pc = PCSEL_INC;
          end
        end else if (is_alu_s) begin
          ctrl_s.we_ac    = 1'b1;
          ctrl_s.z_en     = 1'b1;
          ctrl_s.sel_zero = ZSEL_ALU;
        end else if (is_mvac_s) begin
          ctrl_s.we_r = 1'b1;
        end else if (is_movr_s) begin
          ctrl_s.sel_alu_to_ac = ACSEL_DATA;
          ctrl_s.sel_mem_or_r  = ACSRC_R;
          ctrl_s.we_ac         = 1'b1;
        end else begin
          ctrl_s.we_ac = 1'b0;
        end
      end
      LOAD2: begin
        ctrl_s.sel_alu_to_ac = ACSEL_DATA;
        ctrl_s.sel_mem_or_r  = ACSRC_DREG;
        ctrl_s.we_ac         = 1'b1;
        ctrl_s.instr_done    = 1'b1;
        state_d              = FETCH;
      end
      HALT: begin
        ctrl_s.halted = 1'b1;
        state_d       = HALT;
      end
      default: state_d = FETCH;
    endcase
  end

  // Force every output low while reset is held, independent of run
  always_comb begin
    if (!reset) ctrl_out_s = '0;
    else        ctrl_out_s = ctrl_s;
  end

  assign bus.writeEnableAC             = ctrl_out_s.we_ac;
  assign bus.writeEnableR              = ctrl_out_s.we_r;
  assign bus.writeEnableMem            = ctrl_out_s.we_mem;
  assign bus.PCEnable                  = ctrl_out_s.pc_en;
  assign bus.instructionRegisterEnable = ctrl_out_s.ir_en;
  assign bus.dataRegisterEnable        = ctrl_out_s.dr_en;
  assign bus.MSBaddressEnable          = ctrl_out_s.msb_en;
  assign bus.LSBaddressEnable          = ctrl_out_s.lsb_en;
  assign bus.zeroEnable                = ctrl_out_s.z_en;
  assign bus.muxSelectPC               = ctrl_out_s.sel_pc;
  assign bus.muxSelectZero             = ctrl_out_s.sel_zero;
  assign bus.muxSelectAddress          = ctrl_out_s.sel_addr;
  assign bus.muxSelectALUtoAC          = ctrl_out_s.sel_alu_to_ac;
  assign bus.muxSelectMEM_or_R_toAC    = ctrl_out_s.sel_mem_or_r;
  assign bus.instrDone                 = ctrl_out_s.instr_done;
  assign bus.halted                    = ctrl_out_s.halted;
  assign bus.stateOut                  = STATE_W'(state_q);

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Directed cycle-by-cycle check of the control word for each instruction class.
module tb_accumulator_control_unit;

  // Control word layout: {weAC,weR,weMem,PCEn,IREn,DREn,MSBEn,LSBEn,ZEn,
  //                       selPC,selZ,selAddr,selALUtoAC,selMEMorR,instrDone,halted}
  localparam logic [15:0] V_FETCH  = 16'h1800;
  localparam logic [15:0] V_IDLE   = 16'h0000;
  localparam logic [15:0] V_ADDR1  = 16'h1200;
  localparam logic [15:0] V_ADDR2  = 16'h1100;
  localparam logic [15:0] V_LDAC5  = 16'h0410;
  localparam logic [15:0] V_LOAD2  = 16'h800E;
  localparam logic [15:0] V_ALU    = 16'h8082;
  localparam logic [15:0] V_DONE   = 16'h0002;
  localparam logic [15:0] V_JTAKE  = 16'h1042;
  localparam logic [15:0] V_STAC   = 16'h2012;
  localparam logic [15:0] V_MVAC   = 16'h4002;
  localparam logic [15:0] V_MOVR   = 16'h800A;
  localparam logic [15:0] V_HALT   = 16'h0001;

  logic        clk;
  logic        reset;
  logic [15:0] obs;
  int          errors;
  int          checks;

  accumulator_control_unit_if #(.STATE_W(4)) bus ();

  accumulator_control_unit #(.HALT_OP(8'hFF), .STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign obs = {bus.writeEnableAC, bus.writeEnableR, bus.writeEnableMem, bus.PCEnable,
                bus.instructionRegisterEnable, bus.dataRegisterEnable,
                bus.MSBaddressEnable, bus.LSBaddressEnable, bus.zeroEnable,
                bus.muxSelectPC, bus.muxSelectZero, bus.muxSelectAddress,
                bus.muxSelectALUtoAC, bus.muxSelectMEM_or_R_toAC,
                bus.instrDone, bus.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction of n cycles; exp6 holds per-cycle words, cycle 1 in the MSBs
  task automatic exec_seq(input string tag, input logic [7:0] op, input logic z,
                          input int n, input logic [95:0] exp6, input logic drop_run);
    bus.instructionOut = op;
    bus.ACisZero       = z;
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s c%0d", tag, i + 1), {16'h0000, obs}, {16'h0000, exp6[(5 - i) * 16 +: 16]});
      tick();
      if (drop_run && i == 0) bus.run = 1'b0;
    end
    check_eq($sformatf("%s end state", tag), {28'h0, bus.stateOut}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    bus.run = 1'b1;
    bus.instructionOut = 8'h00;
    bus.ACisZero = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("reset outputs", {16'h0000, obs}, 32'd0);
      check_eq("reset state", {28'h0, bus.stateOut}, 32'd0);
    end
    #2 reset = 1'b1;
    #1;

    exec_seq("ldac", 8'h01, 1'b0, 6, {V_FETCH, V_IDLE, V_ADDR1, V_ADDR2, V_LDAC5, V_LOAD2}, 1'b0);
    exec_seq("add", 8'h08, 1'b0, 3, {V_FETCH, V_IDLE, V_ALU, 48'h0}, 1'b0);
    exec_seq("jmpz nt", 8'h06, 1'b0, 5, {V_FETCH, V_IDLE, V_ADDR1, V_ADDR2, V_DONE, 16'h0}, 1'b0);
    exec_seq("jmpz t", 8'h06, 1'b1, 5, {V_FETCH, V_IDLE, V_ADDR1, V_ADDR2, V_JTAKE, 16'h0}, 1'b0);
    exec_seq("jpnz t", 8'h07, 1'b0, 5, {V_FETCH, V_IDLE, V_ADDR1, V_ADDR2, V_JTAKE, 16'h0}, 1'b0);
    exec_seq("jpnz nt", 8'h07, 1'b1, 5, {V_FETCH, V_IDLE, V_ADDR1, V_ADDR2, V_DONE, 16'h0}, 1'b0);
    exec_seq("jump", 8'h05, 1'b0, 5, {V_FETCH, V_IDLE, V_ADDR1, V_ADDR2, V_JTAKE, 16'h0}, 1'b0);
    exec_seq("mvac", 8'h03, 1'b0, 3, {V_FETCH, V_IDLE, V_MVAC, 48'h0}, 1'b0);
    exec_seq("movr", 8'h04, 1'b1, 3, {V_FETCH, V_IDLE, V_MOVR, 48'h0}, 1'b0);
    exec_seq("nop", 8'h00, 1'b0, 3, {V_FETCH, V_IDLE, V_DONE, 48'h0}, 1'b0);
    exec_seq("undef 3A", 8'h3A, 1'b0, 3, {V_FETCH, V_IDLE, V_DONE, 48'h0}, 1'b0);

    // STAC interrupted by reset in ADDR2 must never write memory
    bus.instructionOut = 8'h02;
    check_eq("stac-rst c1", {16'h0000, obs}, {16'h0000, V_FETCH});
    tick();
    check_eq("stac-rst c2", {16'h0000, obs}, {16'h0000, V_IDLE});
    tick();
    check_eq("stac-rst c3", {16'h0000, obs}, {16'h0000, V_ADDR1});
    tick();
    check_eq("stac-rst c4", {16'h0000, obs}, {16'h0000, V_ADDR2});
    #2 reset = 1'b0;
    #1;
    check_eq("midrst outputs", {16'h0000, obs}, 32'd0);
    check_eq("midrst state", {28'h0, bus.stateOut}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("midrst weMem", {31'h0, bus.writeEnableMem}, 32'd0);
      check_eq("midrst hold state", {28'h0, bus.stateOut}, 32'd0);
    end
    #2 reset = 1'b1;
    #1;
    exec_seq("stac", 8'h02, 1'b0, 5, {V_FETCH, V_IDLE, V_ADDR1, V_ADDR2, V_STAC, 16'h0}, 1'b0);

    // run dropped mid-instruction: the ALU op still completes, then FETCH stalls
    exec_seq("not droprun", 8'h0F, 1'b0, 3, {V_FETCH, V_IDLE, V_ALU, 48'h0}, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check_eq("run0 outputs", {16'h0000, obs}, 32'd0);
      check_eq("run0 state", {28'h0, bus.stateOut}, 32'd0);
      tick();
    end
    #2 bus.run = 1'b1;
    #1;

    bus.instructionOut = 8'hFF;
    check_eq("halt c1", {16'h0000, obs}, {16'h0000, V_FETCH});
    tick();
    check_eq("halt c2", {16'h0000, obs}, {16'h0000, V_IDLE});
    tick();
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("halt hold %0d", i), {16'h0000, obs}, {16'h0000, V_HALT});
      check_eq("halt state", {28'h0, bus.stateOut}, 32'd6);
      tick();
    end
    #2 reset = 1'b0;
    #1;
    check_eq("halt reset outputs", {16'h0000, obs}, 32'd0);
    check_eq("halt reset state", {28'h0, bus.stateOut}, 32'd0);
    tick();
    #2 reset = 1'b1;
    #1;
    check_eq("post-halt fetch", {16'h0000, obs}, {16'h0000, V_FETCH});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accumulator_control_unit.md
Name: accumulator_control_unit

Overview:
- Moore FSM that sequences the 8-bit accumulator datapath: fetch, operand-address fetch, and execute for a 16-opcode accumulator ISA plus HALT.
- Takes the latched opcode and the zero flag from the datapath.
- Drives every datapath register enable, memory write enable and mux select.
- Sits beside the datapath inside the CPU top level; no other block drives the datapath controls.

Parameters:
- HALT_OP, 8'hFF, opcode that parks the FSM in HALT.
- STATE_W, 4, width of the debug state output.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  permits a new instruction fetch; sampled only in FETCH.
- instructionOut  input  8  opcode from the datapath instruction register.
- ACisZero  input  1  zero-flag register from the datapath.
- writeEnableAC, writeEnableR, writeEnableMem  output  1 each  AC, R and memory write enables.
- PCEnable, instructionRegisterEnable, dataRegisterEnable, MSBaddressEnable, LSBaddressEnable, zeroEnable  output  1 each  register enables.
- muxSelectPC, muxSelectZero, muxSelectAddress, muxSelectALUtoAC, muxSelectMEM_or_R_toAC  output  1 each  datapath mux selects.
- instrDone  output  1  one-cycle pulse in the final cycle of every instruction.
- halted  output  1  high while in HALT.
- stateOut  output  STATE_W  current state encoding, for debug.

Behaviour:
- Reset:
  - reset low puts the state in FETCH immediately.
  - While reset is low, all outputs are 0, including instrDone and halted.
  - Reset mid-instruction abandons the instruction. The datapath shares this reset, so PC restarts at 0.
- Default output value: every output is 0 unless a state below asserts it.
- Mux select encodings:
  - muxSelectPC: 0 = PC+1, 1 = {MSB,LSB}.
  - muxSelectAddress: 0 = PC, 1 = {MSB,LSB}.
  - muxSelectALUtoAC: 0 = ALU, 1 = R/data path.
  - muxSelectMEM_or_R_toAC: 0 = R, 1 = data register.
  - muxSelectZero: 0 = ALU result, 1 = AC write data.
- Datapath contract: memory read is combinational from the address mux and writes on the clock edge. The ALU result is valid combinationally in the cycle its operation is selected by instructionOut[2:0].
- Opcodes:
  - 00 NOP; 01 LDAC a; 02 STAC a; 03 MVAC (R<=AC); 04 MOVR (AC<=R); 05 JUMP a; 06 JMPZ a; 07 JPNZ a.
  - 08-0F are ALU ops: ADD, SUB, INAC, CLAC, AND, OR, XOR, NOT.
  - HALT_OP halts.
  - All other opcodes execute as NOP.
  - The operand a is two bytes following the opcode, MSB first.
- States and outputs:
  - FETCH:
    - If run=1: instructionRegisterEnable=1, PCEnable=1, go to DECODE.
    - If run=0: stay in FETCH with no enables.
  - DECODE:
    - HALT_OP goes to HALT.
    - Opcodes 01, 02, 05, 06, 07 go to ADDR1.
    - All others go to EXEC.
  - ADDR1: MSBaddressEnable=1, PCEnable=1, go to ADDR2.
  - ADDR2: LSBaddressEnable=1, PCEnable=1, go to EXEC.
  - EXEC, by opcode:
    - LDAC: muxSelectAddress=1, dataRegisterEnable=1, go to LOAD2.
    - STAC: muxSelectAddress=1, writeEnableMem=1.
    - MVAC: writeEnableR=1.
    - MOVR: muxSelectALUtoAC=1, writeEnableAC=1.
    - JUMP: muxSelectPC=1, PCEnable=1.
    - JMPZ: same as JUMP, only when ACisZero=1.
    - JPNZ: same as JUMP, only when ACisZero=0.
    - ALU ops: writeEnableAC=1, zeroEnable=1, muxSelectZero=0.
    - NOP: no enables.
  - LOAD2: muxSelectALUtoAC=1, muxSelectMEM_or_R_toAC=1, writeEnableAC=1.
  - End of instruction: EXEC (except for LDAC) and LOAD2 assert instrDone and return to FETCH.
  - HALT: halted=1, no enables, stays until reset.
- Zero flag: only ALU ops update Z. LDAC and MOVR leave Z unchanged.
- Latency in cycles:
  - NOP, MVAC, MOVR, ALU ops: 3.
  - STAC, JUMP, JMPZ, JPNZ: 5, whether or not the branch is taken.
  - LDAC: 6.
- run timing: deasserting run mid-instruction does not stall it; the FSM stops at the next FETCH.
- PC wrap-around: PC increments past 16'hFFFF to 16'h0000. This is a datapath behaviour and requires no control action.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams OP_NOP through OP_NOT and OP_HALT;
  - typedef enum state_t {FETCH, DECODE, ADDR1, ADDR2, EXEC, LOAD2, HALT};
  - the mux-select encodings.
- One combinational sub-module, opcode_decode, maps the opcode to class flags: needs_addr, is_load, is_store, is_jump, jump_cond, is_alu, is_halt.

Test Plan:
- Reset: hold reset low for 3 cycles with run=1 → all enables 0 and stateOut=FETCH. After release, instructionRegisterEnable=1 on the first cycle.
- LDAC: run=1, opcode 01 at PC 0, operand bytes 00 10 → MSB/LSB enables on cycles 3 and 4; dataRegisterEnable with muxSelectAddress=1 on cycle 5; writeEnableAC with both AC mux selects=1 on cycle 6; instrDone on cycle 6 only.
- ADD: opcode 08 → writeEnableAC=1, zeroEnable=1, muxSelectZero=0 and instrDone all in cycle 3. No memory or PC enables in cycle 3.
- JMPZ: opcode 06 with ACisZero=0 → no PCEnable in EXEC. With ACisZero=1 → PCEnable=1 and muxSelectPC=1 in EXEC. Both cases take 5 cycles.
- HALT and undefined opcodes: opcode FF → halted=1 from cycle 3 and remains high for 20 cycles with no enables; reset low clears it. Opcode 3A → behaves as NOP, with instrDone on cycle 3.
- run and mid-instruction reset: run=0 → FSM stays in FETCH indefinitely. Reset low during ADDR2 of a STAC → state is FETCH immediately and writeEnableMem is never asserted.
